// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO.
//   fifo_mode_e : read-port mode (registered read or first-word-fall-through)
//   cnt_width() : width needed to hold an occupancy of 0..depth
package fifo_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer for a FIFO of arbitrary depth.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, pointer returns to 0
//   inc : advance the pointer by one this cycle
//   ptr : current pointer, 0..DEPTH-1
module fifo_ptr #(
   parameter  int DEPTH = 8,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   logic [PW-1:0] r_ptr;

   // Explicit wrap at DEPTH-1 so non-power-of-two depths stay in range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (inc) begin
         r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
      end
   end

   assign ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   write_en, data_in : push request and data
//   read_en, data_out : pop request and read data (registered or FWFT)
//   full, empty       : count == DEPTH, count == 0
//   almost_full/empty : count >= AF_THRESH, count <= AE_THRESH
//   count             : current occupancy
//   overflow          : sticky, a write was rejected
//   underflow         : sticky, a read was rejected
//   clr_err           : synchronous clear of both sticky flags
module sync_fifo_flags import fifo_pkg::*; #(
   parameter  int DATA_WIDTH = 16,
   parameter  int DEPTH      = 8,
   parameter  int AF_THRESH  = DEPTH - 2,
   parameter  int AE_THRESH  = 1,
   parameter  int FWFT       = 0,
   localparam int CW         = cnt_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  read_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CW-1:0]         count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_flags: DEPTH must be >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
      $error("sync_fifo_flags: AF_THRESH must be in 1..DEPTH-1");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 2) begin : g_bad_ae
      $error("sync_fifo_flags: AE_THRESH must be in 0..DEPTH-2");
   end
   if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
      $error("sync_fifo_flags: FWFT must be 0 or 1");
   end

   localparam fifo_mode_e MODE = (FWFT == 1) ? FIFO_FWFT : FIFO_STD;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]         r_count;
   logic                  r_overflow;
   logic                  r_underflow;
   logic [PW-1:0]         w_wr_ptr;
   logic [PW-1:0]         w_rd_ptr;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;

   // Flags decode straight off the count register so they all move together.
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // A write into a full FIFO is allowed when a pop frees the slot this edge.
   assign w_wr_acc = write_en && (!w_full || read_en);
   assign w_rd_acc = read_en && !w_empty;

   fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (w_wr_acc),
      .ptr (w_wr_ptr)
   );

   fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (w_rd_acc),
      .ptr (w_rd_ptr)
   );

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[w_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else begin
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Set beats clear when both happen in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (write_en && w_full && !read_en) begin
            r_overflow <= 1'b1;
         end else if (clr_err) begin
            r_overflow <= 1'b0;
         end
         if (read_en && w_empty) begin
            r_underflow <= 1'b1;
         end else if (clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   if (MODE == FIFO_FWFT) begin : g_fwft
      // Head word is presented combinationally; zero while empty.
      assign data_out = w_empty ? '0 : r_mem[w_rd_ptr];
   end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_dout <= '0;
         end else if (w_rd_acc) begin
            r_dout <= r_mem[w_rd_ptr];
         end
      end

      assign data_out = r_dout;
   end

   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= CW'(AF_THRESH));
   assign almost_empty = (r_count <= CW'(AE_THRESH));
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // DEPTH=8 registered-read instance
   logic        wr8 = 0, rd8 = 0, clr8 = 0;
   logic [15:0] din8 = '0, dout8;
   logic        full8, empty8, af8, ae8, ov8, un8;
   logic [3:0]  cnt8;

   // DEPTH=5 registered-read instance
   logic        wr5 = 0, rd5 = 0, clr5 = 0;
   logic [15:0] din5 = '0, dout5;
   logic        full5, empty5, af5, ae5, ov5, un5;
   logic [2:0]  cnt5;

   // DEPTH=8 FWFT instance
   logic        wrf = 0, rdf = 0, clrf = 0;
   logic [15:0] dinf = '0, doutf;
   logic        fullf, emptyf, aff, aef, ovf, unf;
   logic [3:0]  cntf;

   logic [15:0] q8[$];
   logic [15:0] q5[$];
   logic [15:0] qf[$];

   sync_fifo_flags #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_dut (
      .clk(clk), .rst(rst), .write_en(wr8), .data_in(din8), .read_en(rd8), .data_out(dout8),
      .full(full8), .empty(empty8), .almost_full(af8), .almost_empty(ae8), .count(cnt8),
      .overflow(ov8), .underflow(un8), .clr_err(clr8));

   sync_fifo_flags #(.DATA_WIDTH(16), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_dut5 (
      .clk(clk), .rst(rst), .write_en(wr5), .data_in(din5), .read_en(rd5), .data_out(dout5),
      .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5), .count(cnt5),
      .overflow(ov5), .underflow(un5), .clr_err(clr5));

   sync_fifo_flags #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) u_dut_fwft (
      .clk(clk), .rst(rst), .write_en(wrf), .data_in(dinf), .read_en(rdf), .data_out(doutf),
      .full(fullf), .empty(emptyf), .almost_full(aff), .almost_empty(aef), .count(cntf),
      .overflow(ovf), .underflow(unf), .clr_err(clrf));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic sb_extra(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=pop expected=no_pending_data", name);
   endtask

   // Registered-read monitors: a pop seen at a negedge is compared one cycle later.
   initial begin
      logic p8;
      p8 = 1'b0;
      forever begin
         @(negedge clk);
         if (p8) begin
            if (q8.size() == 0) sb_extra("sb8_data");
            else chk("sb8_data", 32'(dout8), 32'(q8.pop_front()));
         end
         p8 = rd8 && !empty8 && !rst;
      end
   end

   initial begin
      logic p5;
      p5 = 1'b0;
      forever begin
         @(negedge clk);
         if (p5) begin
            if (q5.size() == 0) sb_extra("sb5_data");
            else chk("sb5_data", 32'(dout5), 32'(q5.pop_front()));
         end
         p5 = rd5 && !empty5 && !rst;
      end
   end

   // FWFT monitor: the head word is on data_out while it is being popped.
   initial begin
      forever begin
         @(negedge clk);
         if (rdf && !emptyf && !rst) begin
            if (qf.size() == 0) sb_extra("sbf_data");
            else chk("sbf_data", 32'(doutf), 32'(qf.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc8(input logic w, input logic [15:0] d, input logic r, input logic c);
      wr8 = w; din8 = d; rd8 = r; clr8 = c;
      @(posedge clk); #1;
      wr8 = 0; rd8 = 0; clr8 = 0;
   endtask

   task automatic cyc5(input logic w, input logic [15:0] d, input logic r);
      wr5 = w; din5 = d; rd5 = r;
      @(posedge clk); #1;
      wr5 = 0; rd5 = 0;
   endtask

   task automatic cycf(input logic w, input logic [15:0] d, input logic r);
      wrf = w; dinf = d; rdf = r;
      @(posedge clk); #1;
      wrf = 0; rdf = 0;
   endtask

   initial begin
      int rj;
      #3;
      chk("rst_empty", 32'(empty8), 1);
      chk("rst_full", 32'(full8), 0);
      chk("rst_ae", 32'(ae8), 1);
      chk("rst_af", 32'(af8), 0);
      chk("rst_ov", 32'(ov8), 0);
      chk("rst_un", 32'(un8), 0);
      chk("rst_count", 32'(cnt8), 0);
      chk("rst_dout", 32'(dout8), 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // 1: fill to full, then one rejected write
      for (int i = 1; i <= 8; i++) begin
         cyc8(1, 16'(i), 0, 0);
         chk("t1_count", 32'(cnt8), 32'(i));
         chk("t1_ae", 32'(ae8), 32'(i <= 1));
         chk("t1_af", 32'(af8), 32'(i >= 6));
         chk("t1_full", 32'(full8), 32'(i == 8));
      end
      cyc8(1, 16'hBEEF, 0, 0);
      chk("t1_ovf_count", 32'(cnt8), 8);
      chk("t1_ovf_flag", 32'(ov8), 1);

      // 2: write+read on full, then drain
      q8.push_back(16'h0001);
      cyc8(1, 16'h00AA, 1, 0);
      chk("t2_count", 32'(cnt8), 8);
      chk("t2_dout", 32'(dout8), 32'h0001);
      for (int i = 2; i <= 8; i++) begin
         q8.push_back(16'(i));
         cyc8(0, 16'h0, 1, 0);
      end
      q8.push_back(16'h00AA);
      cyc8(0, 16'h0, 1, 0);
      chk("t2_empty", 32'(empty8), 1);
      chk("t2_count0", 32'(cnt8), 0);
      chk("t2_ov_sticky", 32'(ov8), 1);
      cyc8(0, 16'h0, 0, 1);
      chk("t2_ov_clr", 32'(ov8), 0);

      // 3: underflow, clear, set-beats-clear
      cyc8(0, 16'h0, 1, 0);
      chk("t3_un_set", 32'(un8), 1);
      chk("t3_dout_hold", 32'(dout8), 32'h00AA);
      chk("t3_count", 32'(cnt8), 0);
      cyc8(0, 16'h0, 0, 1);
      chk("t3_un_clr", 32'(un8), 0);
      cyc8(0, 16'h0, 1, 1);
      chk("t3_un_win", 32'(un8), 1);

      // 4: DEPTH=5, 15 writes interleaved with reads, pointers wrap
      rj = 0;
      for (int k = 0; k < 15; k++) begin
         if (k >= 3) begin
            q5.push_back(16'h0100 + 16'(rj));
            rj++;
         end
         cyc5(1, 16'h0100 + 16'(k), k >= 3);
         chk("t4_count", 32'(cnt5), (k < 3) ? 32'(k + 1) : 32'd3);
         chk("t4_af", 32'(af5), 32'(k >= 2));
      end
      while (rj < 15) begin
         q5.push_back(16'h0100 + 16'(rj));
         rj++;
         cyc5(0, 16'h0, 1);
      end
      chk("t4_empty", 32'(empty5), 1);
      chk("t4_ov", 32'(ov5), 0);

      // 5: FWFT
      chk("t5_empty0", 32'(emptyf), 1);
      chk("t5_dout0", 32'(doutf), 0);
      cycf(1, 16'h1234, 0);
      chk("t5_empty", 32'(emptyf), 0);
      chk("t5_head", 32'(doutf), 32'h1234);
      qf.push_back(16'h1234);
      cycf(0, 16'h0, 1);
      chk("t5_dout_pop", 32'(doutf), 0);
      chk("t5_empty_pop", 32'(emptyf), 1);
      cycf(1, 16'h5678, 0);
      cycf(1, 16'h9ABC, 0);
      qf.push_back(16'h5678);
      cycf(0, 16'h0, 1);
      chk("t5_next_head", 32'(doutf), 32'h9ABC);
      qf.push_back(16'h9ABC);
      cycf(0, 16'h0, 1);
      chk("t5_empty2", 32'(emptyf), 1);

      // 6: async reset mid-cycle with count=3 and underflow set
      cyc8(1, 16'h0101, 0, 0);
      cyc8(1, 16'h0202, 0, 0);
      cyc8(1, 16'h0303, 0, 0);
      chk("t6_pre_count", 32'(cnt8), 3);
      chk("t6_pre_un", 32'(un8), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_count", 32'(cnt8), 0);
      chk("t6_empty", 32'(empty8), 1);
      chk("t6_ae", 32'(ae8), 1);
      chk("t6_ov", 32'(ov8), 0);
      chk("t6_un", 32'(un8), 0);
      chk("t6_dout", 32'(dout8), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      cyc8(1, 16'h0C0C, 0, 0);
      chk("t6_count1", 32'(cnt8), 1);
      q8.push_back(16'h0C0C);
      cyc8(0, 16'h0, 1, 0);
      chk("t6_count_end", 32'(cnt8), 0);

      repeat (4) @(posedge clk);
      #1;
      chk("sb8_drained", 32'(q8.size()), 0);
      chk("sb5_drained", 32'(q5.size()), 0);
      chk("sbf_drained", 32'(qf.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO, the next generation of the team's basic FIFO, for buffering streams between blocks in the same clock domain.
- Adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags with clear.
- Selectable read mode: registered read or first-word-fall-through (FWFT).
- Supports non-power-of-two depths.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- DEPTH, 8, number of entries; any integer >= 2, power of two not required.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH-1.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-2.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- CW, $clog2(DEPTH+1), count width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- write_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- read_en  in  1  read/pop request.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  CW  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (async, active-high, takes effect without a clock edge):
  - Clears wr_ptr, rd_ptr and count to 0.
  - Outputs: empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0.
  - Memory array is not reset.
- Write accept: wr_acc = write_en && (!full || read_en). On accept, mem[wr_ptr] <= data_in and wr_ptr advances.
- Read accept: rd_acc = read_en && !empty; rd_ptr advances on accept.
- Simultaneous write and read:
  - When full: both accepted, count unchanged.
  - When empty: only the write is accepted; underflow is set.
- Count update: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
- Flags are decoded from the count register, so all flags change on the same edge as count.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. No reliance on power-of-two overflow.
- Registered read (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] at that edge; data is valid after the edge.
  - data_out holds its value when there is no accept.
- FWFT read (FWFT=1):
  - data_out = empty ? 0 : mem[rd_ptr] (combinational).
  - Head word is visible one cycle after the write that made the FIFO non-empty.
  - read_en pops the head.
- Error flags:
  - overflow <= 1 when write_en && full && !read_en.
  - underflow <= 1 when read_en && empty.
  - clr_err clears both flags on the next edge; a set condition in the same cycle wins over clr_err.
- Rejected operations change no pointer, count or memory entry.
- Illegal parameter values trigger an elaboration-time $error.

Decomposition:
- Package fifo_pkg:
  - fifo_mode_e enum (FIFO_STD=0, FIFO_FWFT=1).
  - Function cnt_width(depth) returning $clog2(depth+1).
- Sub-module fifo_ptr (params DEPTH; ports clk, rst, inc, ptr): a wrap-around pointer counter, instantiated once for the write pointer and once for the read pointer.

Test Plan:
Bench uses DEPTH=8, DATA_WIDTH=16, AF_THRESH=6, AE_THRESH=1 unless stated.
1. Reset, write 0x0001..0x0008:
   - count steps 1..8.
   - almost_empty drops at count 2; almost_full rises at count 6; full at 8.
   - A 9th write of 0xBEEF: count stays 8, overflow=1.
2. Full FIFO, write 0x00AA with read_en in the same cycle:
   - count stays 8, data_out=0x0001.
   - Draining then returns 0x0002..0x0008, 0x00AA; empty=1 afterwards.
3. Read while empty:
   - underflow=1, data_out holds its previous value.
   - clr_err: underflow=0 next cycle.
   - clr_err together with a new empty read: underflow stays 1.
4. DEPTH=5: 15 interleaved writes/reads of an incrementing pattern:
   - Both pointers wrap at least twice.
   - Every read matches the write order; count never exceeds 5.
5. FWFT=1, write 0x1234:
   - Next cycle empty=0 and data_out=0x1234 with no read_en.
   - read_en: data_out becomes 0 and empty=1.
6. Count=3, assert rst between clock edges:
   - count=0, empty=1, almost_empty=1, overflow=0, underflow=0 before the next posedge.
   - After release, the first write/read returns the new data.
